// File: rtl/lstm_pkg.sv
// lstm_pkg: shared defaults, FSM state encoding and Q-format word type
// for the LSTM recurrence sequencer.
package lstm_pkg;

   localparam int DATA_WIDTH_DEF  = 16;
   localparam int FRACT_WIDTH_DEF = 8;
   localparam int SEQ_W_DEF       = 8;
   localparam int CELL_LAT_DEF    = 2;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      EVAL,
      EMIT
   } state_t;

   typedef logic signed [DATA_WIDTH_DEF-1:0] q_word_t;

endpackage

// File: rtl/lstm_seq_ctrl_if.sv
// lstm_seq_ctrl_if: control, X/H stream and cell-side signals of the
// sequencer; slave is the sequencer, master is its environment.
interface lstm_seq_ctrl_if #(
   parameter int DW = lstm_pkg::DATA_WIDTH_DEF,
   parameter int SW = lstm_pkg::SEQ_W_DEF
);
   logic          start;
   logic [SW-1:0] seq_len;
   logic          init_load;
   logic [DW-1:0] c_init;
   logic [DW-1:0] h_init;
   logic          x_valid;
   logic          x_ready;
   logic [DW-1:0] x_data;
   logic [DW-1:0] cell_x;
   logic [DW-1:0] cell_c;
   logic [DW-1:0] cell_h;
   logic [DW-1:0] cell_c_out;
   logic [DW-1:0] cell_h_out;
   logic          h_valid;
   logic          h_ready;
   logic [DW-1:0] h_data;
   logic          h_last;
   logic          busy;
   logic          done;

   modport master (
      output start, seq_len, init_load, c_init, h_init,
      output x_valid, x_data, h_ready, cell_c_out, cell_h_out,
      input  x_ready, cell_x, cell_c, cell_h,
      input  h_valid, h_data, h_last, busy, done
   );

   modport slave (
      input  start, seq_len, init_load, c_init, h_init,
      input  x_valid, x_data, h_ready, cell_c_out, cell_h_out,
      output x_ready, cell_x, cell_c, cell_h,
      output h_valid, h_data, h_last, busy, done
   );

endinterface

// File: rtl/lstm_settle_cnt.sv
// lstm_settle_cnt: down-counter giving the combinational cell CELL_LAT
// cycles to settle; o_zero marks the capture cycle.
module lstm_settle_cnt #(
   parameter int CELL_LAT = lstm_pkg::CELL_LAT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   output logic o_zero
);

   logic [3:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= 4'(CELL_LAT - 1);
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl: steps the combinational lstm_cell through a sequence,
// owning the c/h state registers between time steps.
module lstm_seq_ctrl #(
   parameter int DATA_WIDTH  = lstm_pkg::DATA_WIDTH_DEF,
   parameter int FRACT_WIDTH = lstm_pkg::FRACT_WIDTH_DEF,
   parameter int SEQ_W       = lstm_pkg::SEQ_W_DEF,
   parameter int CELL_LAT    = lstm_pkg::CELL_LAT_DEF
) (
   input logic            clk,
   input logic            rst,
   lstm_seq_ctrl_if.slave bus
);
   import lstm_pkg::*;

   if (CELL_LAT < 1 || CELL_LAT > 15 || FRACT_WIDTH >= DATA_WIDTH) begin : g_bad_param
      $error("lstm_seq_ctrl: illegal parameter set");
   end

   state_t                r_state;
   state_t                w_next;
   logic [DATA_WIDTH-1:0] r_x;
   logic [DATA_WIDTH-1:0] r_c;
   logic [DATA_WIDTH-1:0] r_h;
   logic [DATA_WIDTH-1:0] r_hd;
   logic [SEQ_W-1:0]      r_step;
   logic [SEQ_W-1:0]      r_len;
   logic                  r_last;
   logic                  r_done;
   logic                  w_idle;
   logic                  w_go;
   logic                  w_zlen;
   logic                  w_accept;
   logic                  w_capture;
   logic                  w_ack;
   logic                  w_zero;
   logic                  w_x_ready;
   logic                  w_h_valid;

   assign w_idle    = (r_state == IDLE);
   assign w_go      = w_idle && bus.start && (bus.seq_len != '0);
   assign w_zlen    = w_idle && bus.start && (bus.seq_len == '0);
   assign w_accept  = (r_state == LOAD) && bus.x_valid;
   assign w_capture = (r_state == EVAL) && w_zero;
   assign w_ack     = (r_state == EMIT) && bus.h_ready;

   lstm_settle_cnt #(
      .CELL_LAT (CELL_LAT)
   ) u_settle (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_accept),
      .o_zero (w_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_x_ready = 1'b0;
      w_h_valid = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_go) w_next = LOAD;
         end
         LOAD: begin
            w_x_ready = 1'b1;
            if (bus.x_valid) w_next = EVAL;
         end
         EVAL: begin
            if (w_zero) w_next = EMIT;
         end
         EMIT: begin
            w_h_valid = 1'b1;
            if (bus.h_ready) w_next = r_last ? IDLE : LOAD;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_x    <= '0;
         r_c    <= '0;
         r_h    <= '0;
         r_hd   <= '0;
         r_step <= '0;
         r_len  <= '0;
         r_last <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_zlen || (w_ack && r_last);
         if (w_go) begin
            r_c    <= bus.init_load ? bus.c_init : '0;
            r_h    <= bus.init_load ? bus.h_init : '0;
            r_step <= '0;
            r_len  <= bus.seq_len;
         end
         if (w_accept) begin
            r_x <= bus.x_data;
         end
         if (w_capture) begin
            r_c    <= bus.cell_c_out;
            r_h    <= bus.cell_h_out;
            r_hd   <= bus.cell_h_out;
            r_last <= (r_step == r_len - SEQ_W'(1));
         end
         // h_last only qualifies the word while it is being offered
         if (w_ack) begin
            r_last <= 1'b0;
            if (!r_last) r_step <= r_step + SEQ_W'(1);
         end
      end
   end

   assign bus.x_ready = w_x_ready;
   assign bus.h_valid = w_h_valid;
   assign bus.h_data  = r_hd;
   assign bus.h_last  = r_last;
   assign bus.busy    = !w_idle;
   assign bus.done    = r_done;
   assign bus.cell_x  = r_x;
   assign bus.cell_c  = r_c;
   assign bus.cell_h  = r_h;

endmodule

// File: doc/lstm_seq_ctrl.md
Name: lstm_seq_ctrl

Overview:
- Recurrence sequencer for the combinational lstm_cell; it is the other end of the cell's state interface.
- Drives c_in/h_in/X into the cell and captures c_out/h_out back into state registers each time step.
- Streams an input sequence in over valid/ready and streams the per-step hidden state out over valid/ready.
- Sits between the input feature buffer and the downstream dense/output layer.

Parameters:
- DATA_WIDTH, 16, width of X/c/h words (signed Q(DATA_WIDTH-FRACT_WIDTH).FRACT_WIDTH).
- FRACT_WIDTH, 8, fractional bits; carried for consistency only, no arithmetic in this block.
- SEQ_W, 8, width of the sequence-length field and step counter.
- CELL_LAT, 2, settle cycles allowed for the combinational cell path before capture; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to begin a sequence; sampled in IDLE only.
- seq_len  in  SEQ_W  number of time steps; sampled with start.
- init_load  in  1  sampled with start: 1 = load c_init/h_init, 0 = clear state to zero.
- c_init  in  DATA_WIDTH  initial cell state.
- h_init  in  DATA_WIDTH  initial hidden state.
- x_valid  in  1  input sample valid.
- x_ready  out  1  block accepts X.
- x_data  in  DATA_WIDTH  input sample.
- cell_x  out  DATA_WIDTH  to cell X.
- cell_c  out  DATA_WIDTH  to cell c_in.
- cell_h  out  DATA_WIDTH  to cell h_in.
- cell_c_out  in  DATA_WIDTH  from cell c_out.
- cell_h_out  in  DATA_WIDTH  from cell h_out.
- h_valid  out  1  output hidden state valid.
- h_ready  in  1  downstream accepts.
- h_data  out  DATA_WIDTH  hidden state for the step.
- h_last  out  1  qualifies h_data as the final step.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at sequence end.

Behaviour:
- Reset (synchronous, takes priority in every state, including mid-sequence):
  - state goes to IDLE.
  - x_reg, c_reg, h_reg, h_data and the step counter are cleared to 0.
  - x_ready, h_valid, h_last, busy and done are all 0.
- cell_x = x_reg, cell_c = c_reg, cell_h = h_reg. These are direct register outputs with no combinational path from inputs.
- IDLE:
  - On start with seq_len != 0: c_reg/h_reg are loaded from c_init/h_init (init_load=1) or cleared to 0 (init_load=0); step is cleared; go to LOAD.
  - On start with seq_len == 0: done pulses the next cycle; state stays IDLE; c_reg/h_reg are unchanged; no handshakes occur.
- LOAD:
  - x_ready=1.
  - On x_valid: x_reg <= x_data, wait counter <= CELL_LAT-1, go to EVAL.
  - x_ready is 0 in every other state.
- EVAL:
  - Lasts exactly CELL_LAT cycles; the counter decrements each cycle.
  - On the cycle the counter is 0: c_reg <= cell_c_out, h_reg <= cell_h_out, h_data <= cell_h_out, h_last <= (step == seq_len_reg-1), go to EMIT.
- EMIT:
  - h_valid=1.
  - h_data and h_last are held stable until h_ready.
  - On h_ready with h_last=0: step++, go to LOAD.
  - On h_ready with h_last=1: go to IDLE and pulse done for one cycle, coincident with the IDLE entry cycle.
- Latency:
  - X handshake to h_valid = CELL_LAT+1 cycles.
  - Minimum step period = CELL_LAT+2 cycles.
  - Input and output handshakes never overlap.
- seq_len is latched at start into seq_len_reg; changes after start are ignored.
- start while busy is ignored.
- The last step is at step = seq_len_reg-1. The counter never wraps because seq_len <= 2^SEQ_W-1.
- Final c_reg/h_reg persist after done and remain on cell_c/cell_h until the next start or rst.
- x_valid outside LOAD and h_ready outside EMIT have no effect.

Decomposition:
- Shared package lstm_pkg:
  - DATA_WIDTH/FRACT_WIDTH defaults.
  - state enum {IDLE, LOAD, EVAL, EMIT}.
  - Q-format word typedef.
- One natural sub-module: lstm_settle_cnt, the CELL_LAT down-counter with load/zero flag.
- The lstm_cell is instantiated by the parent alongside this block, not inside it.

Test Plan:
- Use a stub cell: c_out = c_in + X, h_out = h_in + 16'h0100.
- Basic sequence: start, seq_len=3, init_load=0, X = 16'h0100, 16'h0200, 16'h0300, h_ready held 1 -> h_data 16'h0100, 16'h0200, 16'h0300; h_last only on the third; final cell_c = 16'h0600; done one pulse; X-accept to h_valid = CELL_LAT+1 cycles.
- Initial state load: init_load=1, c_init=16'h0A00, h_init=16'h0500, seq_len=1, X=16'h0100 -> h_data=16'h0600, h_last=1, cell_c=16'h0B00 after capture.
- Backpressure: h_ready held 0 for 5 cycles in EMIT -> h_valid stays 1, h_data stable, x_ready stays 0; on release, the next X is accepted.
- Zero length: start with seq_len=0 -> done pulse the next cycle, busy never asserts, no x_ready/h_valid.
- Mid-sequence reset: rst asserted in EVAL of step 2 -> next cycle all outputs 0, state IDLE; a following start with seq_len=1 runs normally from zero state.
- Ignored start: start pulsed while busy with a different seq_len -> original sequence length honoured; exactly one done.
